rv32_hazard_ctrl: RTL and testbench

- Pipeline scheduler that generates per-stage stall/flush controls for fetch, decode, execute and mem.
- Sequences the execute stage and its neighbours around four events: load-use hazards, data-bus wait states, branch mispredicts and fences.
- Sits beside the pipeline. Registered FSM plus counters; stall/flush outputs are decoded combinationally from FSM state and current inputs.

---
 rtl/rv32_hazard_pkg.sv | 29 ++
 rtl/rv32_hazard_counter.sv | 33 +++
 rtl/rv32_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rv32_hazard_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_hazard_pkg.sv
// rv32_hazard_pkg: shared types and defaults for the hazard controller.
// Optional bus timeout is enabled by defining RV32_HAZARD_TIMEOUT_EN.
package rv32_hazard_pkg;

   localparam logic [1:0] ENC_IDLE      = 2'b00;
   localparam logic [1:0] ENC_DATA_WAIT = 2'b01;
   localparam logic [1:0] ENC_REDIRECT  = 2'b10;
   localparam logic [1:0] ENC_FENCE     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = ENC_IDLE,
      ST_DATA_WAIT = ENC_DATA_WAIT,
      ST_REDIRECT  = ENC_REDIRECT,
      ST_FENCE     = ENC_FENCE
   } rv32_hazard_state_t;

   localparam int FENCE_CYCLES_DEF   = 4;
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // One width serves both counter instances; never narrower than 8 bits.
   function automatic int cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/rv32_hazard_counter.sv
// rv32_hazard_counter: load/decrement/clear down-counter with
// zero and last-count flags, shared by fence drain and bus timeout.
module rv32_hazard_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero,
   output logic         one
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);
   assign one  = (count == W'(1));

endmodule

// File: rtl/rv32_hazard_ctrl.sv
// rv32_hazard_ctrl: per-stage stall/flush scheduler for the RV32 pipe.
// Define RV32_HAZARD_TIMEOUT_EN to add the sticky data-bus timeout.
module rv32_hazard_ctrl
   import rv32_hazard_pkg::*;
#(
   parameter int FENCE_CYCLES   = FENCE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic [4:0] decode_rs1_in,
   input  logic [4:0] decode_rs2_in,
   input  logic       decode_rs1_read_in,
   input  logic       decode_rs2_read_in,
   input  logic       execute_valid_in,
   input  logic       execute_mem_read_in,
   input  logic [4:0] execute_rd_in,
   input  logic       execute_rd_write_in,
   input  logic       mem_valid_in,
   input  logic       mem_read_in,
   input  logic       mem_write_in,
   input  logic       mem_fence_in,
   input  logic       mem_mispredict_in,
   input  logic       instr_ready_in,
   input  logic       data_ready_in,
   output logic       fetch_stall_out,
   output logic       decode_stall_out,
   output logic       execute_stall_out,
   output logic       mem_stall_out,
   output logic       fetch_flush_out,
   output logic       decode_flush_out,
   output logic       execute_flush_out,
   output logic       mem_flush_out,
   output logic       bus_error_out
);

   localparam int CW = cnt_width(FENCE_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] FENCE_LOAD = CW'(FENCE_CYCLES);

   rv32_hazard_state_t state, next;

   logic mem_access, dwait, mispred, fence_ev;
   logic load_use, iwait, rs_hit;
   logic fs, ds, es, ms, ff, df, ef, mf;
   logic f_load, f_dec, f_clear, f_zero, f_one;

   assign mem_access = mem_valid_in & (mem_read_in | mem_write_in);
   assign dwait      = mem_access & ~data_ready_in;
   assign mispred    = mem_valid_in & mem_mispredict_in;
   assign fence_ev   = mem_valid_in & mem_fence_in;
   assign iwait      = ~instr_ready_in;

   assign rs_hit =
      (decode_rs1_read_in & (decode_rs1_in == execute_rd_in)) |
      (decode_rs2_read_in & (decode_rs2_in == execute_rd_in));

   assign load_use = execute_valid_in & execute_mem_read_in &
                     execute_rd_write_in &
                     (execute_rd_in != 5'd0) & rs_hit;

   rv32_hazard_counter #(.W(CW)) u_fence_cnt (
      .clk        (clk),
      .reset_     (reset_),
      .clear      (f_clear),
      .load       (f_load),
      .load_value (FENCE_LOAD),
      .dec        (f_dec),
      .zero       (f_zero),
      .one        (f_one)
   );

`ifdef RV32_HAZARD_TIMEOUT_EN
   // Loaded on the first wait cycle, so it fires on wait cycle N.
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic t_load, t_dec, t_clear, t_zero, t_one;
   logic timeout, bus_error;

   rv32_hazard_counter #(.W(CW)) u_wait_cnt (
      .clk        (clk),
      .reset_     (reset_),
      .clear      (t_clear),
      .load       (t_load),
      .load_value (TIMEOUT_LOAD),
      .dec        (t_dec),
      .zero       (t_zero),
      .one        (t_one)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         bus_error <= 1'b0;
      end else if (timeout) begin
         bus_error <= 1'b1;
      end
   end

   assign bus_error_out = bus_error;
`else
   assign bus_error_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= ST_IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next    = ST_IDLE;
      fs      = 1'b0;
      ds      = 1'b0;
      es      = 1'b0;
      ms      = 1'b0;
      ff      = 1'b0;
      df      = 1'b0;
      ef      = 1'b0;
      mf      = 1'b0;
      f_load  = 1'b0;
      f_dec   = 1'b0;
      f_clear = 1'b0;
`ifdef RV32_HAZARD_TIMEOUT_EN
      t_load  = 1'b0;
      t_dec   = 1'b0;
      t_clear = 1'b1;
      timeout = 1'b0;
`endif
      if (dwait) begin
         {fs, ds, es, ms} = 4'hF;
         next    = ST_DATA_WAIT;
         f_clear = (state == ST_FENCE);
`ifdef RV32_HAZARD_TIMEOUT_EN
         t_clear = 1'b0;
         if (state != ST_DATA_WAIT) begin
            t_load = 1'b1;
         end else if (t_one | t_zero) begin
            timeout = 1'b1;
            mf      = 1'b1;
            next    = ST_IDLE;
         end else begin
            t_dec = 1'b1;
         end
`endif
      end else if (mispred) begin
         {ff, df, ef} = 3'b111;
         next    = ST_REDIRECT;
         f_clear = 1'b1;
      end else if (state == ST_FENCE) begin
         f_dec = 1'b1;
         // The zero check only guards against a lost count.
         if (f_one | f_zero) begin
            ff = 1'b1;
            df = 1'b1;
         end else begin
            {fs, ds, es} = 3'b111;
            mf   = 1'b1;
            next = ST_FENCE;
         end
      end else begin
         ff = (state == ST_REDIRECT);
         if (fence_ev) begin
            {fs, ds, es} = 3'b111;
            mf     = 1'b1;
            f_load = 1'b1;
            next   = ST_FENCE;
         end else if (load_use) begin
            fs = 1'b1;
            ds = 1'b1;
            ef = 1'b1;
         end else if (iwait && state != ST_REDIRECT) begin
            fs = 1'b1;
            ff = 1'b1;
         end
      end
   end

   // Outputs drop the moment reset asserts, not at the next edge.
   assign fetch_stall_out   = fs & reset_;
   assign decode_stall_out  = ds & reset_;
   assign execute_stall_out = es & reset_;
   assign mem_stall_out     = ms & reset_;
   assign fetch_flush_out   = ff & reset_;
   assign decode_flush_out  = df & reset_;
   assign execute_flush_out = ef & reset_;
   assign mem_flush_out     = mf & reset_;

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// tb_rv32_hazard_ctrl: directed and random checks of the hazard
// controller against an event-level model of the pipeline rules.
module tb_rv32_hazard_ctrl;

   localparam int FC = 4;
   localparam int TO = 8;

   logic       clk;
   logic       reset_;
   logic [4:0] decode_rs1_in;
   logic [4:0] decode_rs2_in;
   logic       decode_rs1_read_in;
   logic       decode_rs2_read_in;
   logic       execute_valid_in;
   logic       execute_mem_read_in;
   logic [4:0] execute_rd_in;
   logic       execute_rd_write_in;
   logic       mem_valid_in;
   logic       mem_read_in;
   logic       mem_write_in;
   logic       mem_fence_in;
   logic       mem_mispredict_in;
   logic       instr_ready_in;
   logic       data_ready_in;
   logic       fetch_stall_out;
   logic       decode_stall_out;
   logic       execute_stall_out;
   logic       mem_stall_out;
   logic       fetch_flush_out;
   logic       decode_flush_out;
   logic       execute_flush_out;
   logic       mem_flush_out;
   logic       bus_error_out;

   logic [7:0] outs;

   int checks;
   int errors;

   // Model: redirect pending, fence cycles left, wait run length.
   bit   m_redirect, n_redirect;
   int   m_fence, n_fence;
   int   m_wait, n_wait;
   bit   m_berr, n_berr;
   logic [7:0] e;

   rv32_hazard_ctrl #(
      .FENCE_CYCLES   (FC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                 (clk),
      .reset_              (reset_),
      .decode_rs1_in       (decode_rs1_in),
      .decode_rs2_in       (decode_rs2_in),
      .decode_rs1_read_in  (decode_rs1_read_in),
      .decode_rs2_read_in  (decode_rs2_read_in),
      .execute_valid_in    (execute_valid_in),
      .execute_mem_read_in (execute_mem_read_in),
      .execute_rd_in       (execute_rd_in),
      .execute_rd_write_in (execute_rd_write_in),
      .mem_valid_in        (mem_valid_in),
      .mem_read_in         (mem_read_in),
      .mem_write_in        (mem_write_in),
      .mem_fence_in        (mem_fence_in),
      .mem_mispredict_in   (mem_mispredict_in),
      .instr_ready_in      (instr_ready_in),
      .data_ready_in       (data_ready_in),
      .fetch_stall_out     (fetch_stall_out),
      .decode_stall_out    (decode_stall_out),
      .execute_stall_out   (execute_stall_out),
      .mem_stall_out       (mem_stall_out),
      .fetch_flush_out     (fetch_flush_out),
      .decode_flush_out    (decode_flush_out),
      .execute_flush_out   (execute_flush_out),
      .mem_flush_out       (mem_flush_out),
      .bus_error_out       (bus_error_out)
   );

   assign outs = {fetch_stall_out, decode_stall_out,
                  execute_stall_out, mem_stall_out,
                  fetch_flush_out, decode_flush_out,
                  execute_flush_out, mem_flush_out};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_redirect = 0;
      m_fence    = 0;
      m_wait     = 0;
      m_berr     = 0;
   endtask

   // e = {fs, ds, es, ms, ff, df, ef, mf}
   task automatic model_eval();
      bit dw, mp, fe, lu, hit;
      dw = mem_valid_in && (mem_read_in || mem_write_in)
           && !data_ready_in;
      mp = mem_valid_in && mem_mispredict_in;
      fe = mem_valid_in && mem_fence_in;
      hit = (decode_rs1_read_in && decode_rs1_in == execute_rd_in)
         || (decode_rs2_read_in && decode_rs2_in == execute_rd_in);
      lu = execute_valid_in && execute_mem_read_in
           && execute_rd_write_in && execute_rd_in != 0 && hit;
      e = 8'h00;
      n_redirect = 0;
      n_fence = m_fence;
      n_wait = 0;
      n_berr = m_berr;
      if (dw) begin
         e[7:4] = 4'hF;
         n_fence = 0;
         n_wait = m_wait + 1;
`ifdef RV32_HAZARD_TIMEOUT_EN
         if (n_wait == TO) begin
            e[0] = 1;
            n_berr = 1;
            n_wait = 0;
         end
`endif
      end else if (mp) begin
         e[3:1] = 3'b111;
         n_redirect = 1;
         n_fence = 0;
      end else if (m_fence > 0) begin
         if (m_fence == 1) begin
            e[3:2] = 2'b11;
            n_fence = 0;
         end else begin
            e[7:5] = 3'b111;
            e[0] = 1;
            n_fence = m_fence - 1;
         end
      end else begin
         if (m_redirect) e[3] = 1;
         if (fe) begin
            e[7:5] = 3'b111;
            e[0] = 1;
            n_fence = FC;
         end else if (lu) begin
            e[7] = 1;
            e[6] = 1;
            e[1] = 1;
         end else if (!instr_ready_in && !m_redirect) begin
            e[7] = 1;
            e[3] = 1;
         end
      end
   endtask

   task automatic set_idle();
      decode_rs1_in       = 5'd0;
      decode_rs2_in       = 5'd0;
      decode_rs1_read_in  = 0;
      decode_rs2_read_in  = 0;
      execute_valid_in    = 0;
      execute_mem_read_in = 0;
      execute_rd_in       = 5'd0;
      execute_rd_write_in = 0;
      mem_valid_in        = 0;
      mem_read_in         = 0;
      mem_write_in        = 0;
      mem_fence_in        = 0;
      mem_mispredict_in   = 0;
      instr_ready_in      = 1;
      data_ready_in       = 1;
   endtask

   task automatic step(input string name, input bit use_lit,
                       input logic [7:0] lit);
      @(negedge clk);
      model_eval();
      checks++;
      if (outs !== e) begin
         errors++;
         $display("FAIL %s outs=%b expected=%b t=%0t",
                  name, outs, e, $time);
      end
      checks++;
      if (bus_error_out !== m_berr) begin
         errors++;
         $display("FAIL %s bus_error=%b expected=%b t=%0t",
                  name, bus_error_out, m_berr, $time);
      end
      if (use_lit) begin
         checks++;
         if (outs !== lit) begin
            errors++;
            $display("FAIL %s_lit outs=%b expected=%b",
                     name, outs, lit);
         end
      end
      @(posedge clk);
      m_redirect = n_redirect;
      m_fence = n_fence;
      m_wait = n_wait;
      m_berr = n_berr;
      #1;
   endtask

   task automatic check_reset_outs(input string name);
      checks++;
      if (outs !== 8'h00 || bus_error_out !== 1'b0) begin
         errors++;
         $display("FAIL %s outs=%b bus_error=%b expected 0",
                  name, outs, bus_error_out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      set_idle();
      model_reset();
      reset_ = 0;
      repeat (2) @(posedge clk);
      #1;
      // Load-use inputs active during reset must not leak out.
      execute_valid_in = 1;
      execute_mem_read_in = 1;
      execute_rd_write_in = 1;
      execute_rd_in = 5'd5;
      decode_rs2_in = 5'd5;
      decode_rs2_read_in = 1;
      #1 check_reset_outs("reset_state");
      @(posedge clk);
      #1 reset_ = 1;
      set_idle();
      step("idle", 1, 8'h00);

      // Load-use on x5, then bubble clears, then rd=x0.
      execute_valid_in = 1;
      execute_mem_read_in = 1;
      execute_rd_write_in = 1;
      execute_rd_in = 5'd5;
      decode_rs2_in = 5'd5;
      decode_rs2_read_in = 1;
      step("load_use", 1, 8'b1100_0010);
      set_idle();
      step("load_use_clear", 1, 8'h00);
      execute_valid_in = 1;
      execute_mem_read_in = 1;
      execute_rd_write_in = 1;
      execute_rd_in = 5'd0;
      decode_rs2_in = 5'd0;
      decode_rs2_read_in = 1;
      step("load_use_x0", 1, 8'h00);

      // Store with three wait cycles.
      set_idle();
      mem_valid_in = 1;
      mem_write_in = 1;
      data_ready_in = 0;
      for (int i = 0; i < 3; i++)
         step("store_wait", 1, 8'b1111_0000);
      data_ready_in = 1;
      step("store_release", 1, 8'h00);

      // Mispredict pulse then REDIRECT.
      set_idle();
      mem_valid_in = 1;
      mem_mispredict_in = 1;
      step("mispredict", 1, 8'b0000_1110);
      set_idle();
      step("redirect", 1, 8'b0000_1000);
      step("after_redirect", 1, 8'h00);

      // Fence drain: four held cycles then refetch.
      mem_valid_in = 1;
      mem_fence_in = 1;
      step("fence_detect", 1, 8'b1110_0001);
      set_idle();
      for (int i = 0; i < FC - 1; i++)
         step("fence_hold", 1, 8'b1110_0001);
      step("fence_refetch", 1, 8'b0000_1100);
      step("after_fence", 1, 8'h00);

      // Mispredict held under a data wait.
      mem_valid_in = 1;
      mem_read_in = 1;
      mem_mispredict_in = 1;
      data_ready_in = 0;
      step("mp_under_wait", 1, 8'b1111_0000);
      step("mp_under_wait", 1, 8'b1111_0000);
      data_ready_in = 1;
      step("mp_release", 1, 8'b0000_1110);
      set_idle();
      step("mp_redirect", 1, 8'b0000_1000);

      // Instruction wait.
      instr_ready_in = 0;
      step("instr_wait", 1, 8'b1000_1000);
      set_idle();

      // Mispredict aborts a fence.
      mem_valid_in = 1;
      mem_fence_in = 1;
      step("fence2_detect", 1, 8'b1110_0001);
      set_idle();
      step("fence2_hold", 1, 8'b1110_0001);
      mem_valid_in = 1;
      mem_mispredict_in = 1;
      step("fence_abort", 1, 8'b0000_1110);
      set_idle();
      step("abort_redirect", 1, 8'b0000_1000);
      step("abort_idle", 1, 8'h00);

      // Asynchronous reset in the middle of a fence.
      mem_valid_in = 1;
      mem_fence_in = 1;
      step("fence3_detect", 1, 8'b1110_0001);
      set_idle();
      #1 reset_ = 0;
      #1 check_reset_outs("reset_mid_fence");
      model_reset();
      @(posedge clk);
      #1 reset_ = 1;
      step("post_reset", 1, 8'h00);

`ifdef RV32_HAZARD_TIMEOUT_EN
      mem_valid_in = 1;
      mem_read_in = 1;
      data_ready_in = 0;
      for (int i = 0; i < TO - 1; i++)
         step("to_wait", 1, 8'b1111_0000);
      step("to_fire", 1, 8'b1111_0001);
      set_idle();
      step("to_sticky", 1, 8'h00);
      checks++;
      if (bus_error_out !== 1'b1) begin
         errors++;
         $display("FAIL bus_error_sticky got=%b want=1",
                  bus_error_out);
      end
      #1 reset_ = 0;
      #1 check_reset_outs("to_reset");
      model_reset();
      @(posedge clk);
      #1 reset_ = 1;
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         decode_rs1_in       = 5'($urandom_range(0, 3));
         decode_rs2_in       = 5'($urandom_range(0, 3));
         decode_rs1_read_in  = 1'($urandom_range(0, 1));
         decode_rs2_read_in  = 1'($urandom_range(0, 1));
         execute_valid_in    = 1'($urandom_range(0, 1));
         execute_mem_read_in = 1'($urandom_range(0, 1));
         execute_rd_in       = 5'($urandom_range(0, 3));
         execute_rd_write_in = ($urandom_range(0, 3) != 0);
         mem_valid_in        = 1'($urandom_range(0, 1));
         mem_read_in         = ($urandom_range(0, 9) < 3);
         mem_write_in        = ($urandom_range(0, 9) < 2);
         mem_fence_in        = ($urandom_range(0, 19) == 0);
         mem_mispredict_in   = ($urandom_range(0, 14) == 0);
         instr_ready_in      = ($urandom_range(0, 9) != 0);
         data_ready_in       = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 399) == 0) begin
            #1 reset_ = 0;
            #1 check_reset_outs("rand_reset");
            model_reset();
            @(posedge clk);
            #1 reset_ = 1;
         end else begin
            step("random", 0, 8'h00);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
